// File: rtl/escalonador_travessia.sv
// -----------------------------------------------------------------------------
// escalonador_travessia
//
// Phase scheduler for a two-road intersection with two pedestrian crosswalks.
// Road A and road B cycle through green, yellow and all-red clearance.
// Button presses are latched. After the next clearance, a protected walk
// phase is inserted. After the walk phase, the scheduler returns to the green
// that would have followed the clearance.
//
// Ports
//   clk   in   system clock, rising edge
//   rst   in   synchronous reset, active-high, dominates all other inputs
//   bt_a  in   crosswalk-A button, level sampled every rising edge
//   bt_b  in   crosswalk-B button, level sampled every rising edge
//   A     out  road-A light, one-hot {vermelho, amarelo, verde}
//   B     out  road-B light, same encoding
//   walk  out  walk[0] crosswalk A, walk[1] crosswalk B; nonzero only in PED
//   fase  out  current state code (debug)
//
// State | meaning
// ------+-------------------------------------------
// AV  0 | A green, B red
// AA  1 | A yellow, B red
// R1  2 | all red, clearance after A
// PED 3 | all red, walk lights per walk_sel
// BV  4 | A red, B green
// BA  5 | A red, B yellow
// R2  6 | all red, clearance after B
// -----------------------------------------------------------------------------
module escalonador_travessia #(
    parameter logic [7:0] T_VERDE     = 8'd8,
    parameter logic [7:0] T_VERDE_MIN = 8'd3,
    parameter logic [7:0] T_AMARELO   = 8'd3,
    parameter logic [7:0] T_VERMELHO  = 8'd2,
    parameter logic [7:0] T_PED       = 8'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt_a,
    input  logic       bt_b,
    output logic [2:0] A,
    output logic [2:0] B,
    output logic [1:0] walk,
    output logic [2:0] fase
);

    typedef enum logic [2:0] {
        AV  = 3'd0,
        AA  = 3'd1,
        R1  = 3'd2,
        PED = 3'd3,
        BV  = 3'd4,
        BA  = 3'd5,
        R2  = 3'd6
    } fase_t;

    localparam logic [2:0] LUZ_VERDE    = 3'b001;
    localparam logic [2:0] LUZ_AMARELO  = 3'b010;
    localparam logic [2:0] LUZ_VERMELHO = 3'b100;

    fase_t      state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [1:0] pend_q, pend_d;        // {pend_b, pend_a}
    logic [1:0] walk_sel_q, walk_sel_d;
    logic       ret_q, ret_d;          // 1: PED was entered from R2
    logic [2:0] a_q, a_d;
    logic [2:0] b_q, b_d;
    logic [1:0] walk_q, walk_d;
    logic [2:0] fase_q, fase_d;

    logic [7:0] dur;
    logic       em_verde;
    logic       pedido;
    logic       sair;

    always_comb begin
        dur = T_PED;
        unique case (state_q)
            AV, BV:  dur = T_VERDE;
            AA, BA:  dur = T_AMARELO;
            R1, R2:  dur = T_VERMELHO;
            default: dur = T_PED;
        endcase
    end

    assign em_verde = (state_q == AV) || (state_q == BV);
    assign pedido   = |pend_q;
    // Green may be cut short once the minimum has elapsed and a request waits.
    assign sair     = (cnt_q == dur) || (em_verde && pedido && (cnt_q >= T_VERDE_MIN));

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 8'd1;  // never wraps: exit happens at cnt == dur <= 255
        pend_d     = pend_q | {bt_b, bt_a};
        walk_sel_d = walk_sel_q;
        ret_d      = ret_q;

        if (sair) begin
            cnt_d = 8'd1;
            unique case (state_q)
                AV:  state_d = AA;
                AA:  state_d = R1;
                R1: begin
                    if (pedido) begin
                        state_d = PED;
                        ret_d   = 1'b0;
                    end else begin
                        state_d = BV;
                    end
                end
                PED: state_d = ret_q ? AV : BV;
                BV:  state_d = BA;
                BA:  state_d = R2;
                R2: begin
                    if (pedido) begin
                        state_d = PED;
                        ret_d   = 1'b1;
                    end else begin
                        state_d = AV;
                    end
                end
                default: state_d = AV;
            endcase

            // Entering PED serves the requests latched so far. A press landing
            // on this same edge survives and waits for the next PED.
            if (state_d == PED) begin
                walk_sel_d = pend_q;
                pend_d     = {bt_b, bt_a};
            end
        end
    end

    // Outputs are decoded from the next state so they are registered
    // alongside it and follow the state register exactly.
    always_comb begin
        a_d = LUZ_VERMELHO;
        b_d = LUZ_VERMELHO;
        unique case (state_d)
            AV:      a_d = LUZ_VERDE;
            AA:      a_d = LUZ_AMARELO;
            BV:      b_d = LUZ_VERDE;
            BA:      b_d = LUZ_AMARELO;
            default: begin
                a_d = LUZ_VERMELHO;
                b_d = LUZ_VERMELHO;
            end
        endcase
        walk_d = (state_d == PED) ? walk_sel_d : 2'b00;
        fase_d = state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= AV;
            cnt_q      <= 8'd1;
            pend_q     <= 2'b00;
            walk_sel_q <= 2'b00;
            ret_q      <= 1'b0;
            a_q        <= LUZ_VERDE;
            b_q        <= LUZ_VERMELHO;
            walk_q     <= 2'b00;
            fase_q     <= AV;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            walk_sel_q <= walk_sel_d;
            ret_q      <= ret_d;
            a_q        <= a_d;
            b_q        <= b_d;
            walk_q     <= walk_d;
            fase_q     <= fase_d;
        end
    end

    assign A    = a_q;
    assign B    = b_q;
    assign walk = walk_q;
    assign fase = fase_q;

endmodule
